vmem_port_arbiter: RTL and testbench
====================================

Name: vmem_port_arbiter

Overview:
- Arbitrates the single 128-bit port B of the shared data memory between two requesters: the vector pipeline (V, memory stage) and the audio sample DMA engine (D), which streams input samples in and filtered samples out.
- Sits between the processor's vector memory interface (data_b / wren_b / q_b) and the memory.
- Default policy is vector priority, with starvation protection and bounded DMA bursts.
- Returns read data to the owning requester with a tagged valid.

Parameters:
AW, 10, word address width of port B
DW, 128, data width
MAX_WAIT, 4, consecutive denied DMA cycles before the DMA is forced to priority (>=1)
MAX_BURST, 8, consecutive locked DMA grants before the vector requester may pre-empt (>=1)
RD_LAT, 1, memory read latency in cycles (1 or 2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low: 0 resets on the clock edge
v_req  in  1  vector access request
v_we  in  1  vector write enable (0 = read)
v_addr  in  AW  vector address
v_wdata  in  DW  vector write data
v_gnt  out  1  vector access accepted this cycle
v_stall  out  1  v_req & ~v_gnt, to the vector hazard unit
v_rvalid  out  1  vector read data valid
v_rdata  out  DW  vector read data
d_req  in  1  DMA request
d_we  in  1  DMA write enable
d_lock  in  1  DMA burst hold request
d_addr  in  AW  DMA address
d_wdata  in  DW  DMA write data
d_gnt  out  1  DMA access accepted this cycle
d_rvalid  out  1  DMA read data valid
d_rdata  out  DW  DMA read data
mem_addr  out  AW  memory port B address
mem_wdata  out  DW  memory port B write data
mem_wren  out  1  memory port B write enable
mem_rdata  in  DW  memory port B read data, valid RD_LAT cycles after the address
arb_state  out  2  0=VPRI, 1=DFORCE, 2=DBURST (registered)

Behaviour:
- Grant logic is combinational from the inputs and the registered state.
  - dma_pri = (state==DFORCE) | (state==DBURST & burst_cnt<MAX_BURST).
  - d_gnt = reset & d_req & (dma_pri | ~v_req).
  - v_gnt = reset & v_req & ~d_gnt.
  - At most one grant per cycle.
- Memory mux:
  - Granted requester's addr, wdata and we drive mem_*.
  - mem_wren = granted & we.
  - With no grant: mem_addr=0, mem_wdata=0, mem_wren=0.
- wait_cnt:
  - Increments when d_req & ~d_gnt, saturating at MAX_WAIT.
  - Clears on d_gnt or ~d_req.
- burst_cnt:
  - Increments on d_gnt & d_lock, saturating at MAX_BURST.
  - Clears on any cycle without (d_gnt & d_lock).
- Next state, in order of precedence:
  - DBURST if d_gnt & d_lock & !(burst_cnt_next==MAX_BURST & v_req).
  - Else DFORCE if wait_cnt_next==MAX_WAIT.
  - Else VPRI.
  - When DBURST hits MAX_BURST and v_req is high, V wins the next cycle (VPRI).
  - If v_req is low, D keeps winning through ~v_req.
- Read return:
  - An RD_LAT-deep tag shift register records {valid=granted & ~we, owner} each cycle.
  - The tag at the output stage drives v_rvalid or d_rvalid.
  - v_rdata = d_rdata = mem_rdata (unqualified; consumers use rvalid).
  - Reads back-to-back, alternating owners, sustain one per cycle.
- Writes produce no rvalid. A write followed by a read to the same address is ordered by the memory (grant order).
- Reset (reset==0 at an edge):
  - state=VPRI; wait_cnt, burst_cnt and all tags cleared.
  - rvalid outputs are 0 on the next cycle.
  - While reset is low, grants and mem_wren are forced 0.
  - In-flight reads are dropped without rvalid.
- Simultaneous v_req & d_req in VPRI: V wins and D's wait_cnt advances.
- d_req dropped mid-burst: burst ends and state returns to VPRI.

Test Plan:
- Reset low 2 cycles with both reqs high -> v_gnt=d_gnt=mem_wren=0; after release with only V reading addr 5 (mem[5]=0xA5..), v_gnt=1 same cycle, and v_rvalid=1, v_rdata=0xA5.. exactly RD_LAT cycles later, d_rvalid=0.
- V and D both request continuously, MAX_WAIT=4 -> V granted 4 cycles, D granted cycle 5 (arb_state=DFORCE during that cycle), pattern repeats every 5 cycles; v_stall high exactly in D cycles.
- D holds d_lock with V requesting, MAX_BURST=8, D in DFORCE first -> D granted 8 consecutive cycles, V granted the 9th, arb_state returns to VPRI.
- Alternating reads V@1, D@2, V@3 in consecutive cycles, RD_LAT=2 -> rvalid pulses arrive in the same order 2 cycles later, each tagged to the correct owner with mem[1], mem[2], mem[3].
- D write 0xDEAD.. to addr 7 then V read addr 7 next cycle -> mem_wren=1 for one cycle with mem_addr=7, and V reads 0xDEAD..
- Reset asserted one cycle after a granted read -> no rvalid emitted, counters at 0, arb_state=VPRI after release.

Source files
------------

// File: rtl/vmem_port_arbiter_if.sv
// Port-B bus between the vector pipeline, the audio DMA engine, the arbiter and the data memory.
// The arbiter takes the slave view; the requesters and the memory together form the master view.
interface vmem_port_arbiter_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 128
);
  logic          v_req;
  logic          v_we;
  logic [AW-1:0] v_addr;
  logic [DW-1:0] v_wdata;
  logic          v_gnt;
  logic          v_stall;
  logic          v_rvalid;
  logic [DW-1:0] v_rdata;

  logic          d_req;
  logic          d_we;
  logic          d_lock;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wren;
  logic [DW-1:0] mem_rdata;

  logic [1:0]    arb_state;

  modport master (
    output v_req, v_we, v_addr, v_wdata,
    input  v_gnt, v_stall, v_rvalid, v_rdata,
    output d_req, d_we, d_lock, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_addr, mem_wdata, mem_wren,
    output mem_rdata,
    input  arb_state
  );

  modport slave (
    input  v_req, v_we, v_addr, v_wdata,
    output v_gnt, v_stall, v_rvalid, v_rdata,
    input  d_req, d_we, d_lock, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_addr, mem_wdata, mem_wren,
    input  mem_rdata,
    output arb_state
  );
endinterface

// File: rtl/vmem_port_arbiter.sv
// Shares memory port B between the vector pipeline and the audio DMA: vector priority,
// DMA starvation forcing, bounded locked DMA bursts, and owner-tagged read return.
module vmem_port_arbiter #(
  parameter int unsigned AW        = 10,
  parameter int unsigned DW        = 128,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned RD_LAT    = 1
) (
  input logic               clk,
  input logic               reset,
  vmem_port_arbiter_if.slave bus
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    VPRI   = 2'd0,
    DFORCE = 2'd1,
    DBURST = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [BW-1:0]       burst_q, burst_d;
  logic [RD_LAT-1:0]   tag_valid_q;
  logic [RD_LAT-1:0]   tag_owner_q;

  logic dma_pri;
  logic d_gnt_c;
  logic v_gnt_c;
  logic d_lock_gnt;
  logic rd_tag;

  // Grant decision and next-state logic
  always_comb begin
    dma_pri    = 1'b0;
    d_gnt_c    = 1'b0;
    v_gnt_c    = 1'b0;
    d_lock_gnt = 1'b0;
    wait_d     = '0;
    burst_d    = '0;
    state_d    = VPRI;

    dma_pri    = (state_q == DFORCE) ||
                 ((state_q == DBURST) && (burst_q < BW'(MAX_BURST)));
    d_gnt_c    = reset & bus.d_req & (dma_pri | ~bus.v_req);
    v_gnt_c    = reset & bus.v_req & ~d_gnt_c;
    d_lock_gnt = d_gnt_c & bus.d_lock;

    if (bus.d_req && !d_gnt_c)
      wait_d = (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + WW'(1);

    if (d_lock_gnt)
      burst_d = (burst_q == BW'(MAX_BURST)) ? burst_q : burst_q + BW'(1);

    // A burst that has used its quota yields to a waiting vector request
    if (d_lock_gnt && !((burst_d == BW'(MAX_BURST)) && bus.v_req))
      state_d = DBURST;
    else if (wait_d == WW'(MAX_WAIT))
      state_d = DFORCE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= VPRI;
      wait_q  <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      burst_q <= burst_d;
    end
  end

  assign rd_tag = (d_gnt_c & ~bus.d_we) | (v_gnt_c & ~bus.v_we);

  // Read tags travel alongside the memory's read pipeline
  generate
    if (RD_LAT == 1) begin : g_tag1
      always_ff @(posedge clk) begin
        if (!reset) begin
          tag_valid_q <= '0;
          tag_owner_q <= '0;
        end else begin
          tag_valid_q <= rd_tag;
          tag_owner_q <= d_gnt_c;
        end
      end
    end else begin : g_tagn
      always_ff @(posedge clk) begin
        if (!reset) begin
          tag_valid_q <= '0;
          tag_owner_q <= '0;
        end else begin
          tag_valid_q <= {tag_valid_q[RD_LAT-2:0], rd_tag};
          tag_owner_q <= {tag_owner_q[RD_LAT-2:0], d_gnt_c};
        end
      end
    end
  endgenerate

  // Port-B mux; idle cycles park the bus at zero
  always_comb begin
    bus.mem_addr  = {AW{1'b0}};
    bus.mem_wdata = {DW{1'b0}};
    bus.mem_wren  = 1'b0;
    if (d_gnt_c) begin
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
      bus.mem_wren  = bus.d_we;
    end else if (v_gnt_c) begin
      bus.mem_addr  = bus.v_addr;
      bus.mem_wdata = bus.v_wdata;
      bus.mem_wren  = bus.v_we;
    end
  end

  assign bus.d_gnt     = d_gnt_c;
  assign bus.v_gnt     = v_gnt_c;
  assign bus.v_stall   = bus.v_req & ~v_gnt_c;
  assign bus.v_rvalid  = tag_valid_q[RD_LAT-1] & ~tag_owner_q[RD_LAT-1];
  assign bus.d_rvalid  = tag_valid_q[RD_LAT-1] &  tag_owner_q[RD_LAT-1];
  assign bus.v_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
  assign bus.arb_state = state_q;

endmodule

// File: tb/tb_vmem_port_arbiter.sv
// Randomized and directed bench for vmem_port_arbiter against a history-based arbitration
// model, a shadow memory and a read-return scoreboard.
module tb_vmem_port_arbiter;
  localparam int unsigned AW        = 10;
  localparam int unsigned DW        = 128;
  localparam int unsigned MAX_WAIT  = 4;
  localparam int unsigned MAX_BURST = 8;
  localparam int unsigned RD_LAT    = 2;
  localparam int unsigned DEPTH     = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vmem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  vmem_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 5) return {16{8'hA5}};
    return {4{32'h1000_0000 + 32'(i)}};
  endfunction

  // Physical memory with an RD_LAT-stage read pipeline
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_pipe [RD_LAT];
  bit            mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (bus.mem_wren) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    rd_pipe[0] <= mem[bus.mem_addr];
    for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[RD_LAT-1];

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: arbitration from request history, shadow memory, return slots by cycle
  logic [DW-1:0] ref_mem [DEPTH];
  int            denied_run = 0;
  int            lock_run   = 0;
  bit            prev_lock_gnt = 1'b0;
  bit            prev_vreq     = 1'b0;
  bit            pend_v [4];
  bit            pend_d [4];
  logic [DW-1:0] pend_data [4];
  int            cyc = 0;

  task automatic step(input bit rst, input bit vr, input bit vw, input logic [AW-1:0] va,
                      input logic [DW-1:0] vd, input bit dr, input bit dw, input bit dl,
                      input logic [AW-1:0] da, input logic [DW-1:0] dd);
    bit            in_burst, forced, dpri, eg_d, eg_v, granted, we;
    logic [1:0]    exp_state;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    int            slot;

    @(negedge clk);
    reset = rst;
    bus.v_req = vr; bus.v_we = vw; bus.v_addr = va; bus.v_wdata = vd;
    bus.d_req = dr; bus.d_we = dw; bus.d_lock = dl; bus.d_addr = da; bus.d_wdata = dd;
    #1;

    in_burst  = prev_lock_gnt && !(lock_run >= int'(MAX_BURST) && prev_vreq);
    forced    = !in_burst && denied_run >= int'(MAX_WAIT);
    exp_state = in_burst ? 2'd2 : (forced ? 2'd1 : 2'd0);
    dpri      = forced || (in_burst && lock_run < int'(MAX_BURST));
    eg_d      = rst && dr && (dpri || !vr);
    eg_v      = rst && vr && !eg_d;
    granted   = eg_d || eg_v;
    we        = eg_d ? dw : (eg_v ? vw : 1'b0);
    ea        = eg_d ? da : (eg_v ? va : '0);
    ewd       = eg_d ? dd : (eg_v ? vd : '0);

    check_eq("arb_state", DW'(bus.arb_state), DW'(exp_state));
    check_eq("d_gnt", DW'(bus.d_gnt), DW'(eg_d));
    check_eq("v_gnt", DW'(bus.v_gnt), DW'(eg_v));
    check_eq("v_stall", DW'(bus.v_stall), DW'(vr && !eg_v));
    check_eq("mem_wren", DW'(bus.mem_wren), DW'(we));
    check_eq("mem_addr", DW'(bus.mem_addr), DW'(ea));
    check_eq("mem_wdata", bus.mem_wdata, ewd);

    slot = cyc % 4;
    check_eq("v_rvalid", DW'(bus.v_rvalid), DW'(pend_v[slot]));
    check_eq("d_rvalid", DW'(bus.d_rvalid), DW'(pend_d[slot]));
    if (pend_v[slot]) check_eq("v_rdata", bus.v_rdata, pend_data[slot]);
    if (pend_d[slot]) check_eq("d_rdata", bus.d_rdata, pend_data[slot]);
    pend_v[slot] = 1'b0;
    pend_d[slot] = 1'b0;

    if (granted && !we) begin
      slot = (cyc + int'(RD_LAT)) % 4;
      pend_v[slot]    = eg_v;
      pend_d[slot]    = eg_d;
      pend_data[slot] = ref_mem[ea];
    end
    if (granted && we) ref_mem[ea] = ewd;

    lock_run      = (eg_d && dl) ? lock_run + 1 : 0;
    denied_run    = (dr && !eg_d) ? denied_run + 1 : 0;
    prev_lock_gnt = eg_d && dl;
    prev_vreq     = vr;

    if (!rst) begin
      lock_run = 0; denied_run = 0; prev_lock_gnt = 1'b0; prev_vreq = 1'b0;
      for (int i = 0; i < 4; i++) begin pend_v[i] = 1'b0; pend_d[i] = 1'b0; end
    end
    cyc++;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [DW-1:0] dead;
    dead = {8{16'hDEAD}};
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);
    for (int i = 0; i < 4; i++) begin pend_v[i] = 1'b0; pend_d[i] = 1'b0; pend_data[i] = '0; end
    reset = 1'b0;
    bus.v_req = 0; bus.v_we = 0; bus.v_addr = '0; bus.v_wdata = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_lock = 0; bus.d_addr = '0; bus.d_wdata = '0;

    // Reset with both requesters active, then a lone vector read of address 5
    repeat (2) step(0, 1, 0, 10'd5, '0, 1, 1, 0, 10'd9, rnd_word());
    repeat (4) step(1, 1, 0, 10'd5, '0, 0, 0, 0, 10'd0, '0);
    // Continuous contention: starvation forcing every MAX_WAIT+1 cycles
    repeat (15) step(1, 1, 0, 10'd10, '0, 1, 0, 0, 10'd11, '0);
    repeat (2) step(1, 0, 0, 10'd0, '0, 0, 0, 0, 10'd0, '0);
    // Locked DMA burst bounded by MAX_BURST against a waiting vector
    repeat (24) step(1, 1, 0, 10'd12, '0, 1, 0, 1, 10'd13, '0);
    repeat (3) step(1, 0, 0, 10'd0, '0, 0, 0, 0, 10'd0, '0);
    // Alternating owners back to back
    step(1, 1, 0, 10'd1, '0, 0, 0, 0, 10'd0, '0);
    step(1, 0, 0, 10'd0, '0, 1, 0, 0, 10'd2, '0);
    step(1, 1, 0, 10'd3, '0, 0, 0, 0, 10'd0, '0);
    repeat (3) step(1, 0, 0, 10'd0, '0, 0, 0, 0, 10'd0, '0);
    // DMA write then vector read of the same word
    step(1, 0, 0, 10'd0, '0, 1, 1, 0, 10'd7, dead);
    step(1, 1, 0, 10'd7, '0, 0, 0, 0, 10'd0, '0);
    repeat (3) step(1, 0, 0, 10'd0, '0, 0, 0, 0, 10'd0, '0);
    // Reset right after a granted read drops the return
    step(1, 1, 0, 10'd4, '0, 0, 0, 0, 10'd0, '0);
    step(0, 1, 0, 10'd6, '0, 1, 0, 0, 10'd8, '0);
    repeat (4) step(1, 0, 0, 10'd0, '0, 0, 0, 0, 10'd0, '0);
    // Random traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      step(($urandom % 64) != 0,
           ($urandom % 10) < 7, ($urandom % 4) == 0, AW'($urandom % 16), rnd_word(),
           ($urandom % 10) < 7, ($urandom % 4) == 0, ($urandom % 3) != 0,
           AW'($urandom % 16), rnd_word());
    end
    repeat (4) step(1, 0, 0, 10'd0, '0, 0, 0, 0, 10'd0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
